// File: rtl/shift_serializer_pkg.sv
// Shared word geometry and serializer state encoding.
// Also used by the byte-accumulating input shift register.
package shift_serializer_pkg;

    localparam int BLOCK_BYTES = 44;
    localparam int BLOCK_BITS  = BLOCK_BYTES * 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/shift_serializer_if.sv
// Load handshake plus byte-stream handshake of the serializer.
interface shift_serializer_if
    import shift_serializer_pkg::*;
#(
    parameter int NBYTES = BLOCK_BYTES
);

    logic                  load_valid;
    logic                  load_ready;
    logic [NBYTES*8-1:0]   load_data;
    logic                  byte_valid;
    logic                  byte_ready;
    logic [7:0]            byte_data;
    logic                  last;
    logic                  done;

    modport master (
        output load_valid,
        output load_data,
        output byte_ready,
        input  load_ready,
        input  byte_valid,
        input  byte_data,
        input  last,
        input  done
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  byte_ready,
        output load_ready,
        output byte_valid,
        output byte_data,
        output last,
        output done
    );

endinterface

// File: rtl/shift_serializer_counter.sv
// Up-counter with synchronous clear; clear has priority over increment.
module shift_serializer_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/shift_serializer.sv
// Parallel-in, byte-serial-out converter; byte 0 (LSB) goes out first
// so the input shift register rebuilds the word bit-for-bit.
module shift_serializer
    import shift_serializer_pkg::*;
#(
    parameter int NBYTES    = BLOCK_BYTES,
    parameter int COUNTBITS = 6
) (
    input  logic             clk,
    input  logic             rst,
    shift_serializer_if.slave bus
);

    localparam logic [COUNTBITS-1:0] LAST_IDX = COUNTBITS'(NBYTES - 1);

    state_t                   state;
    state_t                   state_nx;
    logic [NBYTES-1:0][7:0]   word;
    logic [COUNTBITS-1:0]     index;
    logic                     done_q;
    logic                     done_nx;
    logic                     accept;
    logic                     xfer;
    logic                     at_last;
    logic                     idx_bad;
    logic                     sending;
    logic                     cnt_rst;
    logic                     cnt_inc;

    assign sending = (state == SEND);
    assign at_last = (index == LAST_IDX);
    assign idx_bad = (index > LAST_IDX);
    assign accept  = (state == IDLE) & bus.load_valid;
    assign xfer    = bus.byte_valid & bus.byte_ready;

    // An out-of-range index is treated as an internal reset of the counter.
    assign cnt_rst = rst | accept | (sending & idx_bad);
    assign cnt_inc = xfer & ~at_last;

    shift_serializer_counter #(
        .WIDTH (COUNTBITS)
    ) u_index (
        .clk   (clk),
        .rst   (cnt_rst),
        .inc   (cnt_inc),
        .count (index)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= done_nx;
        end
    end

    // Word register has no reset; its contents only matter in SEND.
    always_ff @(posedge clk) begin
        if (accept & ~rst) begin
            word <= bus.load_data;
        end
    end

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.load_valid) begin
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (idx_bad) begin
                    state_nx = IDLE;
                end else if (xfer & at_last) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.load_ready = (state == IDLE);
    assign bus.byte_valid = sending & ~idx_bad;
    assign bus.last       = sending & at_last;
    assign bus.done       = done_q;
    assign bus.byte_data  = bus.byte_valid ? word[index] : 8'h00;

endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench: cycle table for reset/single word, then streamed
// sequences for backpressure, intrusion, mid-word reset and round-trip.
module tb_shift_serializer;

    import shift_serializer_pkg::*;

    localparam int NB = BLOCK_BYTES;
    localparam int W  = BLOCK_BITS;

    typedef struct {
        logic       rst;
        logic       lv;
        logic       br;
        logic       chk;
        logic       lr;
        logic       bv;
        logic       last;
        logic       done;
        logic [7:0] data;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   nvec = 0;
    int   nfail = 0;

    shift_serializer_if #(.NBYTES(NB)) bus ();

    shift_serializer #(
        .NBYTES    (NB),
        .COUNTBITS (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_word(input string nm, input logic [W-1:0] act,
                              input logic [W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Loads w in the current (idle) cycle, then drains it with byte_ready
    // high one cycle in `period`. Optionally pulses a foreign load at byte
    // `intrude_at`. Ends in the cycle where done must be high.
    task automatic run_stream(input logic [W-1:0] w, input int period,
                              input int intrude_at, input logic [W-1:0] other,
                              output int first_cyc, output int last_cyc);
        logic [W-1:0] sr;
        int  k;
        int  c;
        bit  intruded;
        logic br;
        check("load_ready_idle", 32'(bus.load_ready), 1);
        bus.load_valid = 1'b1;
        bus.load_data  = w;
        bus.byte_ready = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        k = 0;
        c = 0;
        intruded = 0;
        sr = '0;
        first_cyc = cyc;
        last_cyc = cyc;
        while (k < NB && c < NB * 4 + 8) begin
            br = (period <= 1) ? 1'b1 : ((c % period) == 0);
            bus.byte_ready = br;
            if (k == intrude_at && !intruded) begin
                bus.load_valid = 1'b1;
                bus.load_data  = other;
                intruded = 1;
                check("load_ready_in_send", 32'(bus.load_ready), 0);
            end
            check("byte_valid", 32'(bus.byte_valid), 1);
            check($sformatf("byte_data[%0d]", k), 32'(bus.byte_data),
                  32'(w[8*k +: 8]));
            check($sformatf("last[%0d]", k), 32'(bus.last),
                  32'(k == NB - 1));
            check("done_early", 32'(bus.done), 0);
            if (br) begin
                sr = {bus.byte_data, sr[W-1:8]};
                last_cyc = cyc;
                k++;
            end
            tick();
            bus.load_valid = 1'b0;
            c++;
        end
        if (k < NB) begin
            nvec++;
            nfail++;
            $display("FAIL stream_timeout: got %0d bytes required %0d", k, NB);
        end
        check("done_pulse", 32'(bus.done), 1);
        check("load_ready_at_done", 32'(bus.load_ready), 1);
        check("byte_valid_at_done", 32'(bus.byte_valid), 0);
        check_word("roundtrip_word", sr, w);
        bus.byte_ready = 1'b1;
    endtask

    initial begin
        vec_t         tbl[$];
        logic [W-1:0] word_a;
        logic [W-1:0] word_b;
        logic [W-1:0] word_r;
        int           f0, l0, f1, l1;

        for (int k = 0; k < NB; k++) begin
            word_a[8*k +: 8] = 8'(k + 1);
            word_b[8*k +: 8] = 8'(8'hA0 ^ k);
        end
        for (int j = 0; j < W / 32; j++) begin
            word_r[32*j +: 32] = $urandom;
        end

        // Reset, idle, one full word at full rate, done, back to idle.
        tbl.push_back('{rst:1, lv:1, br:1, chk:0, lr:0, bv:0, last:0, done:0, data:0});
        tbl.push_back('{rst:1, lv:0, br:1, chk:1, lr:1, bv:0, last:0, done:0, data:0});
        for (int i = 0; i < 5; i++) begin
            tbl.push_back('{rst:0, lv:0, br:1, chk:1, lr:1, bv:0, last:0, done:0, data:0});
        end
        tbl.push_back('{rst:0, lv:1, br:1, chk:1, lr:1, bv:0, last:0, done:0, data:0});
        for (int k = 0; k < NB; k++) begin
            tbl.push_back('{rst:0, lv:0, br:1, chk:1, lr:0, bv:1,
                            last:(k == NB - 1), done:0, data:8'(k + 1)});
        end
        tbl.push_back('{rst:0, lv:0, br:1, chk:1, lr:1, bv:0, last:0, done:1, data:0});
        tbl.push_back('{rst:0, lv:0, br:1, chk:1, lr:1, bv:0, last:0, done:0, data:0});

        bus.load_data = word_a;
        foreach (tbl[i]) begin
            rst            = tbl[i].rst;
            bus.load_valid = tbl[i].lv;
            bus.byte_ready = tbl[i].br;
            if (tbl[i].chk) begin
                check($sformatf("tbl[%0d].load_ready", i),
                      32'(bus.load_ready), 32'(tbl[i].lr));
                check($sformatf("tbl[%0d].byte_valid", i),
                      32'(bus.byte_valid), 32'(tbl[i].bv));
                check($sformatf("tbl[%0d].last", i),
                      32'(bus.last), 32'(tbl[i].last));
                check($sformatf("tbl[%0d].done", i),
                      32'(bus.done), 32'(tbl[i].done));
                if (tbl[i].bv) begin
                    check($sformatf("tbl[%0d].byte_data", i),
                          32'(bus.byte_data), 32'(tbl[i].data));
                end
            end
            tick();
        end
        rst = 1'b0;
        bus.load_valid = 1'b0;

        // Backpressure: byte_ready high one cycle in three.
        run_stream(word_a, 3, -1, word_b, f0, l0);
        tick();

        // Foreign load pulsed at byte 10 must be ignored.
        run_stream(word_a, 1, 10, word_b, f0, l0);
        tick();
        check("no_capture_after_intrusion", 32'(bus.byte_valid), 0);

        // Reset after byte 20 is accepted.
        bus.load_valid = 1'b1;
        bus.load_data  = word_a;
        bus.byte_ready = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            check("midword_data", 32'(bus.byte_data), 32'(k + 1));
            tick();
        end
        check("midword_byte21", 32'(bus.byte_data), 32'(22));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_byte_valid", 32'(bus.byte_valid), 0);
        check("rst_load_ready", 32'(bus.load_ready), 1);
        check("rst_no_done", 32'(bus.done), 0);
        tick();
        check("rst_no_done_late", 32'(bus.done), 0);

        // Load coinciding with reset: nothing captured.
        rst = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = word_b;
        tick();
        rst = 1'b0;
        bus.load_valid = 1'b0;
        check("rst_load_byte_valid", 32'(bus.byte_valid), 0);
        tick();
        check("rst_load_still_idle", 32'(bus.byte_valid), 0);

        // Fresh load restarts from byte 0.
        run_stream(word_b, 1, -1, word_a, f0, l0);
        tick();

        // Round-trip: random word then all-ones, back to back.
        run_stream(word_r, 1, -1, word_a, f0, l0);
        run_stream({W{1'b1}}, 1, -1, word_a, f1, l1);
        check("b2b_gap", 32'(f1 - l0), 32'(2));
        check("word_span", 32'(l0 - f0), 32'(NB - 1));
        tick();
        check("idle_end", 32'(bus.done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
